if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the pipelined RV32I core. It owns the PC and issues one outstanding request at a time to the instruction memory over a req/ready + rvalid handshake. It captures returned words into the IF/ID register, whose instr_o feeds the immediate generator and decoder in ID. It honours load-use stalls from the hazard unit via a one-entry hold buffer, and squashes wrong-path fetches on a taken-branch flush.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven on instr_o when invalid

Ports:
clk_i  in  1  core clock; all state updates on rising edge
rst_i  in  1  reset, asynchronous, active-high
stall_i  in  1  hold IF/ID contents this cycle (hazard unit)
flush_i  in  1  taken branch resolved in ID; squash IF/ID and redirect
branch_target_i  in  32  redirect PC, sampled when flush_i=1
imem_req_o  out  1  fetch request valid
imem_addr_o  out  32  fetch address (= pc_q)
imem_ready_i  in  1  memory accepts request this cycle
imem_rvalid_i  in  1  response word valid; never in the same cycle as acceptance
imem_rdata_i  in  32  response instruction word
pc_o  out  32  IF/ID: PC of instr_o
instr_o  out  32  IF/ID: instruction to ID (ImmGen/decoder)
valid_o  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, any state):
  - pc_q=RESET_PC, state=FETCH, drop_q=0, buffer empty.
  - pc_o=0, instr_o=NOP_INSTR, valid_o=0.
  - imem_req_o=0 while rst_i=1.
- Internal state:
  - pc_q: address of the next/outstanding fetch.
  - drop_q: outstanding response must be discarded.
  - buf_pc/buf_instr: hold buffer.
- FSM states: FETCH, WAIT, HOLD.
- FETCH:
  - imem_req_o=1, imem_addr_o=pc_q.
  - imem_ready_i=1 -> WAIT. Otherwise stay in FETCH.
- WAIT:
  - imem_req_o=0.
  - On imem_rvalid_i with drop_q=1: discard the word, clear drop_q, -> FETCH. pc_q is unchanged (already the redirect target).
  - On imem_rvalid_i with drop_q=0, stall_i=0: IF/ID <= {pc_q, rdata, valid=1}, pc_q += 4, -> FETCH.
  - On imem_rvalid_i with drop_q=0, stall_i=1: buffer <= {pc_q, rdata}, pc_q += 4, -> HOLD.
- HOLD:
  - imem_req_o=0.
  - stall_i=0: IF/ID <= buffer, valid=1, -> FETCH. Otherwise remain in HOLD.
- Stall:
  - pc_o/instr_o/valid_o unchanged in every cycle where stall_i=1 and flush_i=0.
  - The FETCH state still issues requests during a stall.
- Flush (priority over stall and over any IF/ID load in the same cycle):
  - Always: IF/ID <= {pc_o unchanged, NOP_INSTR, valid=0}; pc_q <= branch_target_i.
  - In FETCH without ready: stay in FETCH. imem_addr_o switches to the target next cycle; address change while req is pending is legal only via flush.
  - In FETCH with ready (request for the old pc accepted): -> WAIT with drop_q=1.
  - In WAIT without rvalid: drop_q <= 1.
  - In WAIT with rvalid the same cycle: the word is discarded, -> FETCH.
  - In HOLD: buffer discarded, -> FETCH.
- Latency:
  - Request accepted at edge N, rvalid at cycle N+k (k>=1). IF/ID is visible the cycle after rvalid.
  - Peak throughput is one instruction per 2 cycles.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0. No alignment check; branch_target_i is used as given.
- rst_i asserted mid-operation: an outstanding response arriving after reset release is not expected (memory is reset together with the core); if it arrives in FETCH it is ignored.

Test Plan:
- Reset release, memory ready=1, rvalid 1 cycle after acceptance, words 0x00500093, 0x00A00113 -> addr 0x0, then 0x4; IF/ID shows {pc 0x0, 0x00500093, v=1}, then {0x4, 0x00A00113, v=1}; one instruction per 2 cycles.
- stall_i held 3 cycles while rvalid arrives with 0x0000A183 -> IF/ID frozen at the prior instruction; state HOLD; IF/ID = 0x0000A183 the cycle after stall_i drops; next request addr = next pc.
- flush_i with target 0x40 while WAIT (request for 0x8 outstanding) -> IF/ID = NOP_INSTR, v=0; returned word for 0x8 discarded; next imem_addr_o = 0x40.
- flush_i and stall_i together in HOLD -> flush wins: buffer discarded, IF/ID = NOP, v=0, next fetch at target.
- flush_i in the same cycle as imem_ready_i in FETCH -> response discarded (drop), following fetch at target; no stale instruction reaches valid_o.
- rst_i asserted in WAIT mid-transaction -> outputs immediately pc_o=0, instr_o=0x00000013, valid_o=0; after release first address = RESET_PC; pc_q at 0xFFFFFFFC advances to 0x0.

Source files
------------

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : RV32I instruction fetch with one outstanding imem request,
//            load-use hold buffer and IF/ID pipeline register.
// Revision : 1.0
// ============================================================================
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_drop;
  logic        w_drop_nxt;
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_instr;
  logic        w_buf_load;
  logic        w_if_load_mem;
  logic        w_if_load_buf;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic        r_if_valid;

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_drop_nxt    = r_drop;
    w_buf_load    = 1'b0;
    w_if_load_mem = 1'b0;
    w_if_load_buf = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (imem_ready_i) begin
          w_state_nxt = ST_WAIT;
          // A flush racing the acceptance leaves a wrong-path word in flight.
          w_drop_nxt  = flush_i;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          w_state_nxt = ST_FETCH;
          w_drop_nxt  = 1'b0;
          if (!r_drop && !flush_i) begin
            w_pc_nxt = r_pc + 32'd4;
            if (stall_i) begin
              w_state_nxt = ST_HOLD;
              w_buf_load  = 1'b1;
            end else begin
              w_if_load_mem = 1'b1;
            end
          end
        end else if (flush_i) begin
          w_drop_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (flush_i) begin
          w_state_nxt = ST_FETCH;
        end else if (!stall_i) begin
          w_state_nxt   = ST_FETCH;
          w_if_load_buf = 1'b1;
        end
      end
      default: w_state_nxt = ST_FETCH;
    endcase
    if (flush_i) begin
      w_pc_nxt = branch_target_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_drop      <= 1'b0;
      r_buf_pc    <= 32'd0;
      r_buf_instr <= NOP_INSTR;
      r_if_pc     <= 32'd0;
      r_if_instr  <= NOP_INSTR;
      r_if_valid  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_drop  <= w_drop_nxt;
      if (w_buf_load) begin
        r_buf_pc    <= r_pc;
        r_buf_instr <= imem_rdata_i;
      end
      // Flush keeps pc_o but turns the slot into a bubble.
      if (flush_i) begin
        r_if_instr <= NOP_INSTR;
        r_if_valid <= 1'b0;
      end else if (w_if_load_mem) begin
        r_if_pc    <= r_pc;
        r_if_instr <= imem_rdata_i;
        r_if_valid <= 1'b1;
      end else if (w_if_load_buf) begin
        r_if_pc    <= r_buf_pc;
        r_if_instr <= r_buf_instr;
        r_if_valid <= 1'b1;
      end
    end
  end

  assign imem_req_o  = (r_state == ST_FETCH) && !rst_i;
  assign imem_addr_o = r_pc;
  assign pc_o        = r_if_pc;
  assign instr_o     = r_if_instr;
  assign valid_o     = r_if_valid;

endmodule
`default_nettype wire
